md_seq_ctrl: RTL and testbench
==============================

Name: md_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from E, runs a 32-iteration radix-2 datapath, and holds the pipeline via stall request while busy.
- Delivers a 64-bit HI/LO result with a one-cycle valid pulse for the M-stage HI/LO write.
- Aborts cleanly on pipeline flush.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset. Synchronous, active-low: sampled on the rising edge of clk, asserted when 0.
- start_i  in  1  E-stage instruction is mult/div; held high by the pipeline while stalled.
- div_i  in  1  1 = divide, 0 = multiply.
- sign_i  in  1  1 = signed operation.
- a_i  in  WIDTH  rs operand (multiplicand or dividend).
- b_i  in  WIDTH  rt operand (multiplier or divisor).
- flush_i  in  1  E-stage flush; cancels any in-flight operation.
- stall_o  out  1  stall request to the hazard unit.
- busy_o  out  1  state != IDLE.
- valid_o  out  1  result valid, one-cycle pulse.
- hi_o  out  WIDTH  HI result (product high half or remainder).
- lo_o  out  WIDTH  LO result (product low half or quotient).

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, counter=0, all datapath registers 0, stall_o=0, busy_o=0, valid_o=0, hi_o=lo_o=0.
- States: IDLE -> BUSY -> FIX -> DONE -> IDLE.
- IDLE:
  - start_i=1 and flush_i=0 at edge T: latch div/sign flags, latch |a_i| and |b_i| (abs only when sign_i=1), record result sign, counter=0, go to BUSY.
  - stall_o is combinationally high in IDLE whenever start_i=1.
- BUSY:
  - One iteration per cycle on cycles T+1 to T+32. Counter increments; counter==ITER-1 moves to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1 bit partial remainder.
- FIX (T+33):
  - Apply sign correction. Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Register the results to hi_o/lo_o.
- DONE (T+34): valid_o=1 and stall_o=0, so E advances this cycle. Next state is IDLE.
- Timing summary: stall_o high for cycles T to T+33 (34 cycles). hi_o/lo_o hold their value until the next FIX.
- A start_i seen in DONE is ignored; it belongs to the same instruction. A new start is accepted only in IDLE.
- flush_i=1 in any state: next state IDLE, counter=0, valid_o=0 next cycle, hi_o/lo_o unchanged. flush_i has priority over start_i and over every state transition.
- Divide by zero (b_i==0 at accept): same latency. FIX forces lo_o=all ones and hi_o=the raw a_i latched at accept; no sign correction.
- Signed -2^31 / -1: lo_o=0x80000000, hi_o=0 (wraps).
- rst has priority over flush_i.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined: multiply uses a single-cycle 2*WIDTH product register. BUSY lasts 1 cycle for multiply, giving valid at T+3 and stall for 3 cycles. Divide is unchanged.
- Undefined: multiply uses the 32-iteration path described above.

Decomposition:
- Package md_pkg:
  - state enum (IDLE, BUSY, FIX, DONE);
  - MD_WIDTH=32, MD_ITER=32;
  - divide-by-zero LO constant (all ones).
- Sub-module md_iter_core: combinational one-step shift-add / shift-subtract logic plus operand registers.
- md_seq_ctrl owns the FSM, counter, sign fix, stall and valid logic.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> stall 34 cycles; valid at T+34 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064 at T+34. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- flush_i pulsed at T+10 during DIV -> IDLE at T+11, stall_o=0, no valid_o, hi/lo keep previous values. Immediate new start is accepted.
- Back-to-back MULTU then DIVU with start_i held through DONE -> exactly two valid pulses, 35 cycles apart.
- rst=0 mid-BUSY -> all outputs 0 next cycle. With MD_FAST_MUL_EN: MULTU 6*7 -> lo=42, valid at T+3.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  // LO value reported for a divide by zero.
  localparam logic [MD_WIDTH-1:0] MD_DBZ_LO = {MD_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Operand registers plus one radix-2 shift-add / restoring shift-subtract step.
// Honours MD_FAST_MUL_EN: multiply collapses to a single full-width product step.
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   op_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [WIDTH-1:0]   raw_a_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic [WIDTH-1:0]   raw_a_o
);

  // op_q holds the multiplicand or the divisor; acc_q low half starts as multiplier or dividend.
  logic [WIDTH-1:0]   op_q,    op_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   rem_q,   rem_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;

  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic               ge_s;

`ifdef MD_FAST_MUL_EN
  assign mul_next_s = {{WIDTH{1'b0}}, op_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  logic [WIDTH:0] add_s;
  assign add_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {add_s, acc_q[WIDTH-1:1]};
`endif

  // The trial remainder needs one extra bit; the kept remainder always fits in WIDTH.
  assign shift_s = {rem_q, acc_q[WIDTH-1]};
  assign ge_s    = (shift_s >= {1'b0, op_q});
  assign diff_s  = shift_s - {1'b0, op_q};

  // Next-state selection for the operand and accumulator registers.
  always_comb begin
    op_d    = op_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    raw_a_d = raw_a_q;
    if (load_i) begin
      op_d    = op_i;
      acc_d   = {{WIDTH{1'b0}}, lo_i};
      rem_d   = {WIDTH{1'b0}};
      raw_a_d = raw_a_i;
    end else if (step_i) begin
      if (div_i) begin
        rem_d = ge_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge_s};
      end else begin
        acc_d = mul_next_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      raw_a_q <= {WIDTH{1'b0}};
    end else begin
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      raw_a_q <= raw_a_d;
    end
  end

  assign acc_o   = acc_q;
  assign rem_o   = rem_q;
  assign raw_a_o = raw_a_q;

endmodule

// File: rtl/md_seq_ctrl.sv
// E-stage multiply/divide sequencer: FSM, iteration counter, sign fix, stall and valid.
// Honours MD_FAST_MUL_EN: multiply spends one cycle in BUSY instead of ITER.
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(ITER);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               load_s, step_s, last_s, fast_mul_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [2*WIDTH-1:0] acc_s, prod_fix_s;
  logic [WIDTH-1:0]   rem_s, raw_a_s, quo_fix_s, rem_fix_s;

  assign a_mag_s = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag_s = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_s),
    .step_i  (step_s),
    .div_i   (div_q),
    .op_i    (div_i ? b_mag_s : a_mag_s),
    .lo_i    (div_i ? a_mag_s : b_mag_s),
    .raw_a_i (a_i),
    .acc_o   (acc_s),
    .rem_o   (rem_s),
    .raw_a_o (raw_a_s)
  );

`ifdef MD_FAST_MUL_EN
  assign fast_mul_s = !div_q;
`else
  assign fast_mul_s = 1'b0;
`endif

  assign last_s     = (cnt_q == CNT_W'(ITER - 1)) || fast_mul_s;
  assign prod_fix_s = neg_res_q ? -acc_s : acc_s;
  assign quo_fix_s  = neg_res_q ? -acc_s[WIDTH-1:0] : acc_s[WIDTH-1:0];
  assign rem_fix_s  = neg_rem_q ? -rem_s : rem_s;

  // Sequencer next state; flush beats start and every transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    valid_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    load_s    = 1'b0;
    step_s    = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            load_s    = 1'b1;
            div_d     = div_i;
            neg_res_d = sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_d = sign_i & a_i[WIDTH-1];
            dbz_d     = (b_i == {WIDTH{1'b0}});
            cnt_d     = {CNT_W{1'b0}};
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          step_s = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_s) begin
            state_d = FIX;
          end else begin
            state_d = BUSY;
          end
        end
        FIX: begin
          state_d = DONE;
          valid_d = 1'b1;
          if (!div_q) begin
            hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
          end else if (dbz_q) begin
            hi_d = raw_a_s;
            lo_d = MD_DBZ_LO;
          end else begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      valid_q   <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      valid_q   <= valid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // The IDLE term lets the hazard unit hold E in the very cycle the op is accepted.
  assign stall_o = ((state_q == IDLE) && start_i) || (state_q == BUSY) || (state_q == FIX);
  assign busy_o  = (state_q != IDLE);
  assign valid_o = valid_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed self-checking bench for md_seq_ctrl (MD_FAST_MUL_EN selects the short multiply latency).
module tb_md_seq_ctrl;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, div_i, sign_i, flush_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, busy_o, valid_o;
  logic [31:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  md_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .div_i   (div_i),
    .sign_i  (sign_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  // Called just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic run_op(input logic dv, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input string name);
    int  lat;
    int  stalls;
    bit  got;
    lat = 0; stalls = 0; got = 1'b0;
    div_i = dv; sign_i = sg; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk);
    if (stall_o) stalls++;
    for (int n = 1; n <= exp_lat + 4 && !got; n++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (valid_o) begin
        got = 1'b1;
        lat = n;
      end
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (stalls !== exp_lat) begin
      n_err++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_lat);
    end
    n_vec++;
    if (hi_o !== exp_hi) begin
      n_err++; $display("FAIL %s hi: got %h expected %h", name, hi_o, exp_hi);
    end
    n_vec++;
    if (lo_o !== exp_lo) begin
      n_err++; $display("FAIL %s lo: got %h expected %h", name, lo_o, exp_lo);
    end
    n_vec++;
    if ({valid_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL %s after_done valid/busy: got %b expected 00", name, {valid_o, busy_o});
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start_i = 1'b0; div_i = 1'b0; sign_i = 1'b0; flush_i = 1'b0;
    a_i = 32'h0; b_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({stall_o, busy_o, valid_o} !== 3'b000) begin
      n_err++; $display("FAIL reset flags: got %b expected 000", {stall_o, busy_o, valid_o});
    end
    n_vec++;
    if ({hi_o, lo_o} !== 64'h0) begin
      n_err++; $display("FAIL reset hilo: got %h expected 0", {hi_o, lo_o});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, "multu_max");
    run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, "mult_neg3x7");
    run_op(1'b0, 1'b0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, MUL_LAT, "multu_6x7");
    run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_LAT, "mult_neg1sq");
  endtask

  task automatic test_div;
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, "div_neg7_2");
    run_op(1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT, "div_7_neg2");
    run_op(1'b1, 1'b0, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, DIV_LAT, "divu_by0");
    run_op(1'b1, 1'b1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT, "div_neg5_by0");
    run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, "div_min_neg1");
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DIV_LAT, "divu_max_16");
  endtask

  task automatic test_flush;
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DIV_LAT, "divu_pre_flush");
    div_i = 1'b1; sign_i = 1'b0; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL flush_accept busy: got %b expected 1", busy_o);
    end
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    n_vec++;
    if ({stall_o, busy_o, valid_o} !== 3'b000) begin
      n_err++; $display("FAIL flush_idle flags: got %b expected 000", {stall_o, busy_o, valid_o});
    end
    n_vec++;
    if ({hi_o, lo_o} !== {32'h0000000F, 32'h0FFFFFFF}) begin
      n_err++; $display("FAIL flush_hold hilo: got %h expected 0000000f0fffffff", {hi_o, lo_o});
    end
    // A spurious completion of the flushed divide would shorten this op's observed latency.
    run_op(1'b0, 1'b0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, MUL_LAT, "multu_after_flush");
    start_i = 1'b1; flush_i = 1'b1; div_i = 1'b1; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk); #1;
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL flush_over_start busy: got %b expected 0", busy_o);
    end
    start_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int v_cnt;
    int first_cyc;
    int second_cyc;
    v_cnt = 0; first_cyc = -1; second_cyc = -1;
    div_i = 1'b0; sign_i = 1'b0; a_i = 32'h12345678; b_i = 32'h00000010; start_i = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (valid_o) begin
        if (v_cnt == 0) begin
          first_cyc = cyc;
          n_vec++;
          if ({hi_o, lo_o} !== 64'h00000001_23456780) begin
            n_err++; $display("FAIL b2b_mul hilo: got %h expected 0000000123456780", {hi_o, lo_o});
          end
        end else if (v_cnt == 1) begin
          second_cyc = cyc;
          n_vec++;
          if ({hi_o, lo_o} !== 64'h00000006_0000008E) begin
            n_err++; $display("FAIL b2b_div hilo: got %h expected 000000060000008e", {hi_o, lo_o});
          end
        end else begin
          second_cyc = second_cyc;
        end
        v_cnt++;
        @(posedge clk); #1;
        if (v_cnt == 1) begin
          div_i = 1'b1; a_i = 32'd1000; b_i = 32'd7;
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    n_vec++;
    if (v_cnt !== 2) begin
      n_err++; $display("FAIL b2b_pulses: got %0d expected 2", v_cnt);
    end
    n_vec++;
    if (first_cyc !== MUL_LAT) begin
      n_err++; $display("FAIL b2b_first_valid: got %0d expected %0d", first_cyc, MUL_LAT);
    end
    n_vec++;
    if (second_cyc - first_cyc !== 35) begin
      n_err++; $display("FAIL b2b_gap: got %0d expected 35", second_cyc - first_cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy;
    div_i = 1'b1; sign_i = 1'b1; a_i = 32'hFFFFFFF9; b_i = 32'h00000002; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL midbusy busy: got %b expected 1", busy_o);
    end
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({stall_o, busy_o, valid_o} !== 3'b000) begin
      n_err++; $display("FAIL midbusy_reset flags: got %b expected 000", {stall_o, busy_o, valid_o});
    end
    n_vec++;
    if ({hi_o, lo_o} !== 64'h0) begin
      n_err++; $display("FAIL midbusy_reset hilo: got %h expected 0", {hi_o, lo_o});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, "div_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
